// File: rtl/weight_init_lfsr.sv
// Seeds the weight RAM with a deterministic LFSR-derived sequence after each start pulse.
// Optional read-back check of the written contents is enabled with WINIT_READBACK_EN.
module weight_init_lfsr #(
    parameter int unsigned NUM_WEIGHTS  = 165,
    parameter int unsigned DATA_W       = 10,
    parameter int unsigned ADDR_W       = 8,
    parameter logic [15:0] SEED         = 16'hACE1,
    parameter int unsigned WEIGHT_SHIFT = 3
) (
    input  logic              Clock,
    input  logic              Rst,
    input  logic              start,
    input  logic              grant,
    input  logic [DATA_W-1:0] ram_q,
    output logic [DATA_W-1:0] ram_d,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic              busy,
    output logic              done,
    output logic              verify_err
);

    localparam int unsigned LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_WEIGHTS - 1);

`ifdef WINIT_READBACK_EN
    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE, S_VERIFY} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;
`endif

    state_t             state, state_n;
    logic [ADDR_W-1:0]  idx, idx_n;
    logic [LFSR_W-1:0]  lfsr, lfsr_n;
    logic [LFSR_W-1:0]  lfsr_adv;
    logic signed [DATA_W-1:0] weight;

`ifdef WINIT_READBACK_EN
    logic [DATA_W-1:0]  exp_q, exp_n;
    logic               chk_q, chk_n;
    logic               vlast_q, vlast_n;
    logic               err_q, err_n;
`endif

    // Galois step and scaled weight derived from the current LFSR value
    assign lfsr_adv = (lfsr >> 1) ^ (lfsr[0] ? LFSR_MASK : '0);
    assign weight   = $signed(lfsr[DATA_W-1:0]) >>> WEIGHT_SHIFT;

    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            state <= S_IDLE;
            idx   <= '0;
            lfsr  <= SEED;
`ifdef WINIT_READBACK_EN
            exp_q   <= '0;
            chk_q   <= 1'b0;
            vlast_q <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            idx   <= idx_n;
            lfsr  <= lfsr_n;
`ifdef WINIT_READBACK_EN
            exp_q   <= exp_n;
            chk_q   <= chk_n;
            vlast_q <= vlast_n;
            err_q   <= err_n;
`endif
        end
    end

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        lfsr_n   = lfsr;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_d    = '0;
        busy     = 1'b0;
        done     = 1'b0;
`ifdef WINIT_READBACK_EN
        exp_n    = exp_q;
        chk_n    = 1'b0;
        vlast_n  = vlast_q;
        // Read data returns one cycle after the address; compare against the staged expectation
        err_n    = err_q | (chk_q && (ram_q != exp_q));
`endif

        case (state)
            S_IDLE, S_DONE: begin
                done = (state == S_DONE);
                if (start) begin
                    state_n = S_FILL;
                    idx_n   = '0;
                    lfsr_n  = SEED;
`ifdef WINIT_READBACK_EN
                    err_n   = 1'b0;
                    vlast_n = 1'b0;
`endif
                end
            end

            S_FILL: begin
                busy     = 1'b1;
                ram_we   = grant;
                ram_addr = idx;
                ram_d    = weight;
                if (grant) begin
                    lfsr_n = lfsr_adv;
                    if (idx == LAST_IDX) begin
`ifdef WINIT_READBACK_EN
                        state_n = S_VERIFY;
                        idx_n   = '0;
                        lfsr_n  = SEED;
                        vlast_n = 1'b0;
`else
                        state_n = S_DONE;
`endif
                    end else begin
                        idx_n = idx + ADDR_W'(1);
                    end
                end
            end

`ifdef WINIT_READBACK_EN
            S_VERIFY: begin
                busy = 1'b1;
                if (vlast_q) begin
                    // Final compare resolves this cycle
                    state_n = S_DONE;
                end else begin
                    ram_addr = idx;
                    if (grant) begin
                        chk_n  = 1'b1;
                        exp_n  = weight;
                        lfsr_n = lfsr_adv;
                        if (idx == LAST_IDX) begin
                            vlast_n = 1'b1;
                        end else begin
                            idx_n = idx + ADDR_W'(1);
                        end
                    end
                end
            end
`endif

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

`ifdef WINIT_READBACK_EN
    assign verify_err = err_q;
`else
    logic unused_ram_q;
    assign unused_ram_q = ^ram_q;
    assign verify_err   = 1'b0;
`endif

endmodule

// File: tb/tb_weight_init_lfsr.sv
// Bench for weight_init_lfsr: reference weight table plus a cycle model of the fill sequence.
module tb_weight_init_lfsr;

    localparam int NW = 165;

    logic       Clock = 1'b0;
    logic       Rst   = 1'b1;
    logic       start = 1'b0;
    logic       grant = 1'b0;
    logic [9:0] ram_q = '0;
    logic [9:0] ram_d;
    logic [7:0] ram_addr;
    logic       ram_we, busy, done, verify_err;

    int checks = 0;
    int errors = 0;
    int exp_w[NW];
    int m_st  = 0;   // 0 idle, 1 filling, 2 done
    int m_idx = 0;
    int n_wr, n_busy;
    int hit[NW];
    logic [9:0] mem[256];

    weight_init_lfsr dut (
        .Clock(Clock), .Rst(Rst), .start(start), .grant(grant), .ram_q(ram_q),
        .ram_d(ram_d), .ram_addr(ram_addr), .ram_we(ram_we), .busy(busy),
        .done(done), .verify_err(verify_err)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference weights: LFSR walk, low 10 bits as signed, divided by 8 rounding toward -inf
    task automatic build_table();
        logic [15:0] lf;
        int raw;
        lf = 16'hACE1;
        for (int i = 0; i < NW; i++) begin
            raw = int'(lf[9:0]);
            if (raw >= 512) raw = raw - 1024;
            exp_w[i] = raw >>> 3;
            lf = {1'b0, lf[15:1]} ^ (lf[0] ? 16'hB400 : 16'h0000);
        end
    endtask

    // Sequence model: where the fill should be after each edge
    always @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            m_st  = 0;
            m_idx = 0;
        end else begin
            case (m_st)
                0, 2: if (start) begin m_st = 1; m_idx = 0; end
                1: if (grant) begin
                    if (m_idx == NW - 1) m_st = 2;
                    else m_idx++;
                end
                default: m_st = 0;
            endcase
        end
    end

    always @(negedge Clock) begin
        if (!Rst) begin
            chk("ram_we", int'(ram_we), int'(m_st == 1 && grant));
            chk("ram_addr", int'(ram_addr), (m_st == 1) ? m_idx : 0);
            chk("ram_d", int'($signed(ram_d)), (m_st == 1) ? exp_w[m_idx] : 0);
            chk("busy", int'(busy), int'(m_st == 1));
            chk("done", int'(done), int'(m_st == 2));
            chk("verify_err", int'(verify_err), 0);
            if (ram_we) begin
                n_wr++;
                if (int'(ram_addr) < NW) hit[ram_addr]++;
            end
            if (busy) n_busy++;
        end
    end

    // RAM with one-cycle registered read
    always @(posedge Clock) begin
        if (ram_we) mem[ram_addr] <= ram_d;
        ram_q <= mem[ram_addr];
    end

    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    task automatic run(input bit toggle, input int glitch, input int exp_edges, input int exp_busy);
        int edges;
        int cov;
        n_wr = 0;
        n_busy = 0;
        foreach (hit[i]) hit[i] = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        edges = 1;
        if (toggle) grant = 1'b0;
        else begin
            #1;
            chk("first_addr", int'(ram_addr), 0);
            chk("first_d", int'($signed(ram_d)), 28);
        end
        while (!done && edges < 1000) begin
            tick();
            edges++;
            if (toggle) grant = ~grant;
            start = (edges == glitch);
            if (!toggle && edges == 2) begin
                chk("second_addr", int'(ram_addr), 1);
                chk("second_d", int'($signed(ram_d)), -50);
            end
        end
        start = 1'b0;
        grant = 1'b1;
        chk("done_edges", edges, exp_edges);
        chk("write_count", n_wr, NW);
        chk("busy_cycles", n_busy, exp_busy);
        cov = 0;
        foreach (hit[i]) if (hit[i] == 1) cov++;
        chk("addr_once", cov, NW);
    endtask

    initial begin
        int n;
        build_table();
        foreach (mem[i]) mem[i] = 10'h155;
        #1;
        chk("rst_we", int'(ram_we), 0);
        chk("rst_addr", int'(ram_addr), 0);
        chk("rst_d", int'(ram_d), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_verr", int'(verify_err), 0);
        chk("table_w0", exp_w[0], 28);
        chk("table_w1", exp_w[1], -50);
        tick();
        Rst = 1'b0;
        tick();
        tick();

        grant = 1'b1;
        run(1'b0, 0, 166, 165);
        repeat (3) tick();
        chk("done_level", int'(done), 1);

        run(1'b1, 0, 331, 330);
        repeat (2) tick();

        // Reset in the middle of a fill
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (int'(ram_addr) != 80 && n < 300) begin
            tick();
            n++;
        end
        chk("reached_80", int'(ram_addr), 80);
        Rst = 1'b1;
        #1;
        chk("midrst_we", int'(ram_we), 0);
        chk("midrst_addr", int'(ram_addr), 0);
        chk("midrst_d", int'(ram_d), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        tick();
        Rst = 1'b0;
        tick();
        chk("idle_after_rst", int'(busy), 0);
        run(1'b0, 0, 166, 165);

        // Start pulse mid-fill must be ignored, then a restart from DONE
        run(1'b0, 40, 166, 165);
        run(1'b0, 0, 166, 165);
        tick();

        for (int a = 0; a < NW; a++) chk("ram_content", int'($signed(mem[a])), exp_w[a]);
        chk("ram_untouched", int'(mem[NW]), 'h155);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
